// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: adds a WIDTH-bit operand pair CHUNK bits per clock
// with a registered carry between slices, behind valid/ready handshakes on both sides.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int N    = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [IDXW-1:0]  idx_q;

    int               lsb;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] res_chunk;
    logic             chunk_cout;
    logic             msb_cin;

    // One CHUNK-wide slice of the adder; msb_cin is only meaningful on the last slice.
    always_comb begin
        lsb                     = int'(idx_q) * CHUNK;
        a_chunk                 = op_a_q[lsb +: CHUNK];
        b_chunk                 = op_b_q[lsb +: CHUNK];
        {chunk_cout, res_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        msb_cin                 = res_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    end

    assign in_ready_o  = (state_q == IDLE) && !rst;
    assign out_valid_o = (state_q == DONE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

    // Subtraction is folded into the accept: a - b - cin == a + ~b + !cin.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        op_a_q  <= a_i;
                        op_b_q  <= sub_i ? ~b_i : b_i;
                        carry_q <= cin_i ^ sub_i;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[lsb +: CHUNK] <= res_chunk;
                    carry_q             <= chunk_cout;
                    idx_q               <= idx_q + IDXW'(1);
                    if (idx_q == IDXW'(N - 1)) begin
                        cout_q  <= chunk_cout;
                        ovf_q   <= msb_cin ^ chunk_cout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
